// File: rtl/mips32_mem_arbiter.sv
// Two-requester (IF fetch / MEM data) arbiter in front of a single-ported memory macro.
// Optional `MEM_ARB_RR_EN selects strict alternation instead of data priority with a starvation limit.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t        state, state_nxt;
  logic          pick_d;
  logic          win_d;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_cnt;
  logic          flushed;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;

`ifdef MEM_ARB_RR_EN
  logic          last_win_d;

  always_comb begin
    pick_d = d_req && (!if_req || !last_win_d);
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0]    starve_cnt;

  always_comb begin
    pick_d = d_req && (!if_req || (starve_cnt != STARVE_LIM));
  end
`endif

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (if_req || d_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if_gnt    = !win_d;
        d_gnt     = win_d;
        state_nxt = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) state_nxt = RESP;
      end
      RESP: begin
        // a flush arriving in the response cycle itself still suppresses the fetch
        if_rvalid = !win_d && !flushed && !if_flush;
        d_rvalid  = win_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_d      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_cnt    <= '0;
      flushed    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_win_d <= 1'b0;
`else
      starve_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            win_d     <= pick_d;
            lat_we    <= pick_d && d_we;
            lat_addr  <= pick_d ? d_addr : if_addr;
            lat_wdata <= pick_d ? d_wdata : '0;
            lat_cnt   <= '0;
            flushed   <= 1'b0;
          end
        end
        ISSUE: begin
          flushed <= flushed || (if_flush && !win_d);
`ifdef MEM_ARB_RR_EN
          last_win_d <= win_d;
`else
          if (win_d && if_req) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
`endif
        end
        WAIT: begin
          flushed <= flushed || (if_flush && !win_d);
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == LAT_LAST) begin
            if (win_d) d_rdata_q  <= mem_rdata;
            else       if_rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state != IDLE);

endmodule
